// File: rtl/inst_buffer_pkg.sv
// Shared CPU types and constants used by the front end.
// Holds the fetch-to-decode packet format and the default instruction buffer depth.
package inst_buffer_pkg;

  localparam int INST_BUFFER_DEPTH = 8;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [7:0]  exception;
  } fetch_to_decode_bus_t;

  // Number of occupied slots in a two-slot fetch packet.
  function automatic logic [1:0] slot_count(input fetch_to_decode_bus_t a,
                                            input fetch_to_decode_bus_t b);
    return {1'b0, a.valid} + {1'b0, b.valid};
  endfunction

endpackage

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: a circular queue of DEPTH entries,
// two in / two out per cycle. Optional same-cycle bypass via INST_BUFFER_BYPASS_EN.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = INST_BUFFER_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 fetch_valid,
  input  fetch_to_decode_bus_t fetch_inst1,
  input  fetch_to_decode_bus_t fetch_inst2,
  output logic                 ib_allowin,
  output logic                 fs_to_valid,
  input  logic                 ds_allowin,
  output fetch_to_decode_bus_t fetch_to_decode_bus1,
  output fetch_to_decode_bus_t fetch_to_decode_bus2
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  fetch_to_decode_bus_t entries [DEPTH];

  ptr_t head, tail, head_p1, tail_p1;
  cnt_t count, count_next;

  logic       enq_fire, deq_fire, bypass_fire;
  logic [1:0] enq_n, wr_n, deq_n;

  fetch_to_decode_bus_t first_slot, second_slot;

  assign head_p1 = head + ptr_t'(1);
  assign tail_p1 = tail + ptr_t'(1);

  // Accept only when a full two-slot packet is guaranteed to fit.
  assign ib_allowin = (count <= cnt_t'(DEPTH - 2));
  assign enq_fire   = fetch_valid && ib_allowin && !flush;

  // Compaction: a lone slot2 moves to the first write position.
  always_comb begin
    first_slot        = fetch_inst1.valid ? fetch_inst1 : fetch_inst2;
    second_slot       = fetch_inst2;
    first_slot.valid  = fetch_inst1.valid | fetch_inst2.valid;
    second_slot.valid = fetch_inst1.valid & fetch_inst2.valid;
    enq_n             = slot_count(fetch_inst1, fetch_inst2);
  end

`ifdef INST_BUFFER_BYPASS_EN
  assign bypass_fire = enq_fire && ds_allowin && (count == '0) && (enq_n != 2'd0);
`else
  assign bypass_fire = 1'b0;
`endif

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    fetch_to_decode_bus1       = entries[head];
    fetch_to_decode_bus1.valid = (count != '0);
    fetch_to_decode_bus2       = entries[head_p1];
    fetch_to_decode_bus2.valid = (count >= cnt_t'(2));
    fs_to_valid                = (count != '0);
`ifdef INST_BUFFER_BYPASS_EN
    if (bypass_fire) begin
      fetch_to_decode_bus1 = first_slot;
      fetch_to_decode_bus2 = second_slot;
      fs_to_valid          = 1'b1;
    end
`endif
  end

  assign deq_fire = fs_to_valid && ds_allowin && !flush;

  always_comb begin
    deq_n = 2'd0;
    if (deq_fire) deq_n = (count >= cnt_t'(2)) ? 2'd2 : count[1:0];
    wr_n = (enq_fire && !bypass_fire) ? enq_n : 2'd0;
    count_next = count + cnt_t'(wr_n) - cnt_t'(deq_n);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + ptr_t'(deq_n);
      tail  <= tail + ptr_t'(wr_n);
      count <= count_next;
    end
  end

  // NOTE: payload storage has no reset; count == 0 already marks every entry as invalid.
  always_ff @(posedge clk) begin
    if (wr_n != 2'd0) entries[tail]    <= first_slot;
    if (wr_n == 2'd2) entries[tail_p1] <= second_slot;
  end

endmodule
